adc_frame_aligner: RTL

- Parametrised successor to the fixed 4-channel/16-bit ADC capture path.
- Sits after the per-lane ISERDES/IDELAY front end, in the clk_adc domain.
- Takes raw parallel words per channel plus the sampled FCO word, and aligns the word boundary with a fabric bitslip search against the FCO pattern.
- Reports lock, outputs aligned samples with a valid flag, and provides a per-channel test-pattern checker for bring-up.

---
 rtl/adc_intf_pkg.sv | 22 ++
 rtl/adc_bitslip_window.sv | 39 +++
 rtl/adc_frame_aligner.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_intf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_intf_pkg
// Brief    : Shared FSM state codes and constants for the ADC capture path.
// Revision : 1.0
// ============================================================================
package adc_intf_pkg;

  typedef logic [2:0] adc_state_t;

  localparam adc_state_t c_ST_IDLE   = 3'd0;
  localparam adc_state_t c_ST_SETTLE = 3'd1;
  localparam adc_state_t c_ST_SEARCH = 3'd2;
  localparam adc_state_t c_ST_VERIFY = 3'd3;
  localparam adc_state_t c_ST_LOCKED = 3'd4;
  localparam adc_state_t c_ST_FAIL   = 3'd5;

  localparam logic [15:0] c_DEFAULT_FCO_PATTERN = 16'hFF00;
  localparam int          c_ERR_CNT_W           = 16;

endpackage
`default_nettype wire

// File: rtl/adc_bitslip_window.sv
`default_nettype none
// ============================================================================
// Module   : adc_bitslip_window
// Brief    : One lane of the fabric bitslip: {prev,cur} >> slip, registered.
// Revision : 1.0
// ============================================================================
module adc_bitslip_window
  import adc_intf_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                        clk_adc,
  input  logic                        rst,
  input  logic [SAMPLE_W-1:0]         raw,
  input  logic [$clog2(SAMPLE_W)-1:0] slip,
  output logic [SAMPLE_W-1:0]         aligned
);

  logic [SAMPLE_W-1:0] r_prev;
  logic [SAMPLE_W-1:0] r_aligned;
  logic [SAMPLE_W-1:0] w_aligned;

  // Low bits of the previous word fill the top when slip is non-zero.
  assign w_aligned = SAMPLE_W'({r_prev, raw} >> slip);

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      r_prev    <= '0;
      r_aligned <= '0;
    end else begin
      r_prev    <= raw;
      r_aligned <= w_aligned;
    end
  end

  assign aligned = r_aligned;

endmodule
`default_nettype wire

// File: rtl/adc_frame_aligner.sv
`default_nettype none
// ============================================================================
// Module   : adc_frame_aligner
// Brief    : FCO-driven word alignment, lock tracking and test-pattern check.
// Revision : 1.0
// ============================================================================
module adc_frame_aligner
  import adc_intf_pkg::*;
#(
  parameter int                  NUM_CH      = 4,
  parameter int                  SAMPLE_W    = 16,
  parameter logic [SAMPLE_W-1:0] FCO_PATTERN = SAMPLE_W'(c_DEFAULT_FCO_PATTERN),
  parameter int                  SETTLE      = 2,
  parameter int                  LOCK_CNT    = 64,
  parameter int                  LOSS_CNT    = 4
) (
  input  logic                            clk_adc,
  input  logic                            rst,
  input  logic [SAMPLE_W-1:0]             raw_fco,
  input  logic [NUM_CH*SAMPLE_W-1:0]      raw_data,
  input  logic                            align_start,
  input  logic                            chk_en,
  input  logic [SAMPLE_W-1:0]             chk_pattern,
  input  logic                            chk_clr,
  output logic [NUM_CH*SAMPLE_W-1:0]      dout,
  output logic                            dout_valid,
  output logic                            locked,
  output logic                            align_fail,
  output logic [$clog2(SAMPLE_W)-1:0]     slip,
  output logic [NUM_CH-1:0]               chk_err,
  output logic [NUM_CH*c_ERR_CNT_W-1:0]   chk_err_cnt
);

  localparam int c_SLIP_W   = $clog2(SAMPLE_W);
  localparam int c_TRIED_W  = $clog2(SAMPLE_W + 1);
  localparam int c_SETTLE_W = $clog2(SETTLE + 1);
  localparam int c_MATCH_W  = $clog2(LOCK_CNT + 1);
  localparam int c_LOSS_W   = $clog2(LOSS_CNT + 1);
  localparam int c_LANES    = NUM_CH + 1;

  localparam logic [c_SLIP_W-1:0]   c_SLIP_MAX    = c_SLIP_W'(SAMPLE_W - 1);
  localparam logic [c_TRIED_W-1:0]  c_TRIED_MAX   = c_TRIED_W'(SAMPLE_W);
  localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(SETTLE - 1);
  localparam logic [c_MATCH_W-1:0]  c_LOCK_LAST   = c_MATCH_W'(LOCK_CNT - 1);
  localparam logic [c_LOSS_W-1:0]   c_LOSS_LAST   = c_LOSS_W'(LOSS_CNT - 1);

  logic [c_LANES*SAMPLE_W-1:0] w_raw_all;
  logic [c_LANES*SAMPLE_W-1:0] w_aligned_all;
  logic [NUM_CH*SAMPLE_W-1:0]  w_data_aligned;
  logic [SAMPLE_W-1:0]         w_fco_aligned;

  adc_state_t              r_state;
  logic [c_SLIP_W-1:0]     r_slip;
  logic [c_TRIED_W-1:0]    r_tried;
  logic [c_SETTLE_W-1:0]   r_settle_cnt;
  logic [c_MATCH_W-1:0]    r_match_cnt;
  logic [c_LOSS_W-1:0]     r_loss_cnt;
  logic                    r_align_fail;
  logic [NUM_CH*SAMPLE_W-1:0] r_dout;
  logic                    r_dout_valid;

  logic                    w_fco_match;
  logic                    w_locked;
  logic [c_TRIED_W-1:0]    w_tried_inc;
  logic [c_SLIP_W-1:0]     w_slip_next;

  // Lanes 0..NUM_CH-1 carry data, the top lane carries FCO; all share one slip.
  assign w_raw_all = {raw_fco, raw_data};

  for (genvar k = 0; k < c_LANES; k++) begin : g_lane
    adc_bitslip_window #(
      .SAMPLE_W (SAMPLE_W)
    ) u_window (
      .clk_adc (clk_adc),
      .rst     (rst),
      .raw     (w_raw_all[k*SAMPLE_W +: SAMPLE_W]),
      .slip    (r_slip),
      .aligned (w_aligned_all[k*SAMPLE_W +: SAMPLE_W])
    );
  end

  assign w_data_aligned = w_aligned_all[NUM_CH*SAMPLE_W-1:0];
  assign w_fco_aligned  = w_aligned_all[c_LANES*SAMPLE_W-1 -: SAMPLE_W];

  assign w_fco_match = (w_fco_aligned == FCO_PATTERN);
  assign w_locked    = (r_state == c_ST_LOCKED);
  assign w_tried_inc = r_tried + 1'b1;
  assign w_slip_next = (r_slip == c_SLIP_MAX) ? '0 : r_slip + 1'b1;

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      r_state      <= c_ST_IDLE;
      r_slip       <= '0;
      r_tried      <= '0;
      r_settle_cnt <= '0;
      r_match_cnt  <= '0;
      r_loss_cnt   <= '0;
      r_align_fail <= 1'b0;
    end else if (align_start) begin
      r_state      <= c_ST_SETTLE;
      r_slip       <= '0;
      r_tried      <= '0;
      r_settle_cnt <= '0;
      r_match_cnt  <= '0;
      r_loss_cnt   <= '0;
      r_align_fail <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          r_state      <= c_ST_SETTLE;
          r_slip       <= '0;
          r_tried      <= '0;
          r_settle_cnt <= '0;
        end
        c_ST_SETTLE: begin
          if (r_settle_cnt == c_SETTLE_LAST) begin
            r_state      <= c_ST_SEARCH;
            r_settle_cnt <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        c_ST_SEARCH, c_ST_VERIFY: begin
          if (w_fco_match) begin
            if (r_state == c_ST_SEARCH) begin
              r_state     <= c_ST_VERIFY;
              r_match_cnt <= c_MATCH_W'(1);
            end else begin
              r_match_cnt <= r_match_cnt + 1'b1;
              if (r_match_cnt == c_LOCK_LAST) begin
                r_state    <= c_ST_LOCKED;
                r_loss_cnt <= '0;
              end
            end
          end else begin
            // A miss in VERIFY costs an offset just like a miss in SEARCH.
            r_tried     <= w_tried_inc;
            r_match_cnt <= '0;
            if (w_tried_inc == c_TRIED_MAX) begin
              r_state      <= c_ST_FAIL;
              r_align_fail <= 1'b1;
            end else begin
              r_slip       <= w_slip_next;
              r_settle_cnt <= '0;
              r_state      <= c_ST_SETTLE;
            end
          end
        end
        c_ST_LOCKED: begin
          if (w_fco_match) begin
            r_loss_cnt <= '0;
          end else if (r_loss_cnt == c_LOSS_LAST) begin
            // Re-search starts from the slip that was working.
            r_state      <= c_ST_SETTLE;
            r_tried      <= '0;
            r_settle_cnt <= '0;
            r_match_cnt  <= '0;
            r_loss_cnt   <= '0;
          end else begin
            r_loss_cnt <= r_loss_cnt + 1'b1;
          end
        end
        c_ST_FAIL: begin
          r_state <= c_ST_FAIL;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout       <= w_data_aligned;
      r_dout_valid <= w_locked;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chk
    logic                   r_err;
    logic [c_ERR_CNT_W-1:0] r_cnt;
    logic                   w_mis;

    assign w_mis = chk_en && w_locked &&
                   (w_data_aligned[k*SAMPLE_W +: SAMPLE_W] != chk_pattern);

    always_ff @(posedge clk_adc or posedge rst) begin
      if (rst) begin
        r_err <= 1'b0;
        r_cnt <= '0;
      end else if (chk_clr) begin
        r_err <= 1'b0;
        r_cnt <= '0;
      end else if (w_mis) begin
        r_err <= 1'b1;
        if (r_cnt != '1) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign chk_err[k]                               = r_err;
    assign chk_err_cnt[k*c_ERR_CNT_W +: c_ERR_CNT_W] = r_cnt;
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign locked     = w_locked;
  assign align_fail = r_align_fail;
  assign slip       = r_slip;

endmodule
`default_nettype wire
